c16_mdu: RTL

C16_MDU -- requirements
Module: c16_mdu

---
 rtl/c16_pkg.sv | 26 ++
 rtl/c16_mdu.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/c16_pkg.sv
// c16_pkg -- shared definitions for the c16 multiply/divide unit.
//
// Holds the MDU sequencer state encoding and the op_div / op_signed
// encodings so the c16 core's xmul/xdiv states can drive the unit with
// the same names the unit uses internally.
package c16_pkg;

  // MDU sequencer states.
  //   ST_IDLE : waiting for start; results from the last operation held.
  //   ST_RUN  : one shift-add / shift-subtract step per cycle.
  //   ST_FIX  : sign correction and result registration; pulses done.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } c16_state_t;

  // op_div encoding
  localparam logic OP_MUL      = 1'b0;
  localparam logic OP_DIV      = 1'b1;

  // op_signed encoding
  localparam logic OP_UNSIGNED = 1'b0;
  localparam logic OP_SIGNED   = 1'b1;

endpackage

// File: rtl/c16_mdu.sv
// c16_mdu -- iterative radix-2 multiply / restoring divide unit.
//
// Ports:
//   clk        sole clock, rising edge
//   resetn     asynchronous active-low reset
//   start      request a new operation (sampled only in ST_IDLE)
//   op_div     OP_MUL / OP_DIV
//   op_signed  OP_UNSIGNED / OP_SIGNED
//   a, b       multiplicand/multiplier or dividend/divisor
//   busy       operation in progress (low in the cycle done is high)
//   done       one-cycle pulse: res_lo/res_hi/div_zero are valid
//   res_lo     low product half or quotient
//   res_hi     high product half or remainder
//   div_zero   divide with b == 0 (res_lo = all ones, res_hi = a)
//   dbg_state  current sequencer state, for observation only
//
// Handshake: start is accepted on a rising edge where the unit is in
// ST_IDLE and start is high; a, b, op_div and op_signed are captured on
// that edge and are don't-care afterwards. Exactly one done pulse follows
// each accepted start (WIDTH+1 edges later, or 1 edge for divide by
// zero) unless resetn intervenes. start while busy is dropped. A start
// presented while done is high is accepted (the unit is already idle).
//
// Datapath: a 2*WIDTH+1 bit shift register acc holds the partial
// product / partial remainder in the upper WIDTH+1 bits and the
// multiplier / dividend-quotient in the lower WIDTH bits. A single
// WIDTH+1 bit adder serves both operations: for divide the addend is
// inverted with carry-in set, giving rem - divisor.
module c16_mdu
  import c16_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             op_div,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic             div_zero,
  output c16_state_t       dbg_state
);

  localparam int              CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  c16_state_t         state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH:0]   acc;
  logic [WIDTH-1:0]   m;        // multiplicand or divisor magnitude
  logic               is_div;
  logic               neg_lo;   // negate product / quotient in ST_FIX
  logic               neg_hi;   // negate remainder in ST_FIX
  logic               dz;       // divide by zero in flight

  assign dbg_state = state;

  // Operand magnitudes, formed at acceptance. The most negative value
  // maps onto itself, which read as unsigned is the correct magnitude.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    a_neg = (op_signed == OP_SIGNED) & a[WIDTH-1];
    b_neg = (op_signed == OP_SIGNED) & b[WIDTH-1];
    a_mag = a_neg ? (~a + WIDTH'(1)) : a;
    b_mag = b_neg ? (~b + WIDTH'(1)) : b;
  end

  // Shared adder/subtractor and the next value of acc for one step.
  logic [WIDTH:0]   add_x, add_y, add_sum;
  logic [2*WIDTH:0] mul_next, div_next;

  always_comb begin
    if (is_div) begin
      // Partial remainder after the left shift: acc[2W-1:W-1].
      add_x = acc[2*WIDTH-1:WIDTH-1];
      add_y = ~{1'b0, m};
    end else begin
      add_x = acc[2*WIDTH:WIDTH];
      add_y = acc[0] ? {1'b0, m} : '0;
    end
    add_sum  = add_x + add_y + {{WIDTH{1'b0}}, is_div};
    mul_next = {1'b0, add_sum, acc[WIDTH-1:1]};
    // No borrow (sum MSB clear) means the divisor fit: keep the
    // difference and shift in a 1 quotient bit; otherwise restore.
    if (!add_sum[WIDTH])
      div_next = {add_sum, acc[WIDTH-2:0], 1'b1};
    else
      div_next = {acc[2*WIDTH-1:WIDTH-1], acc[WIDTH-2:0], 1'b0};
  end

  // Sign-corrected results, consumed in ST_FIX.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    prod_fix = neg_lo ? (~acc[2*WIDTH-1:0] + (2*WIDTH)'(1)) : acc[2*WIDTH-1:0];
    quo_fix  = neg_lo ? (~acc[WIDTH-1:0] + WIDTH'(1)) : acc[WIDTH-1:0];
    rem_fix  = neg_hi ? (~acc[2*WIDTH-1:WIDTH] + WIDTH'(1)) : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      acc      <= '0;
      m        <= '0;
      is_div   <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      dz       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      res_lo   <= '0;
      res_hi   <= '0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            is_div <= op_div;
            if (op_div == OP_DIV && b == '0) begin
              // Keep the raw dividend; it is returned as res_hi.
              dz    <= 1'b1;
              acc   <= {{(WIDTH+1){1'b0}}, a};
              m     <= '0;
              state <= ST_FIX;
            end else begin
              dz     <= 1'b0;
              neg_lo <= a_neg ^ b_neg;
              neg_hi <= a_neg;
              if (op_div == OP_DIV) begin
                acc <= {{(WIDTH+1){1'b0}}, a_mag};
                m   <= b_mag;
              end else begin
                acc <= {{(WIDTH+1){1'b0}}, b_mag};
                m   <= a_mag;
              end
              state <= ST_RUN;
            end
          end
        end

        ST_RUN: begin
          acc <= is_div ? div_next : mul_next;
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= ST_FIX;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        ST_FIX: begin
          if (dz) begin
            res_lo   <= '1;
            res_hi   <= acc[WIDTH-1:0];
            div_zero <= 1'b1;
          end else if (is_div) begin
            res_lo   <= quo_fix;
            res_hi   <= rem_fix;
            div_zero <= 1'b0;
          end else begin
            res_lo   <= prod_fix[WIDTH-1:0];
            res_hi   <= prod_fix[2*WIDTH-1:WIDTH];
            div_zero <= 1'b0;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
